// File: rtl/cnt1_stream.sv
// Streaming popcount pre-stage: forwards BUS_WIDTH beats with 3-cycle latency and
// attaches the vector's total set-bit count to the last beat of each vector.
module cnt1_stream #(
    parameter int BUS_WIDTH     = 128,
    parameter int SUB_VECTOR_NO = 2,
    parameter int VECTOR_WIDTH  = BUS_WIDTH * SUB_VECTOR_NO,
    parameter int GRANULE_WIDTH = 6,
    parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_Vector,
    input  logic                 i_Valid,
    output logic                 o_Ready,
    output logic [BUS_WIDTH-1:0] o_SubVector,
    output logic                 o_Valid,
    output logic                 o_Last,
    output logic [CNT_WIDTH-1:0] o_Cnt,
    input  logic                 i_Ready
);

    localparam int NUM_GRAN = (BUS_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
    localparam int PAD_WIDTH = NUM_GRAN * GRANULE_WIDTH;
    localparam int GCW = $clog2(GRANULE_WIDTH + 1);
    localparam int BCW = $clog2(BUS_WIDTH + 1);
    localparam int IDXW = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SUB_VECTOR_NO - 1);

    logic                 en;
    logic                 accept;
    logic [IDXW-1:0]      beat_idx;

    logic [PAD_WIDTH-1:0] padded;
    logic [GCW-1:0]       gran_cnt_d [NUM_GRAN];

    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    logic [BUS_WIDTH-1:0] s1_beat;
    logic [GCW-1:0]       s1_gran [NUM_GRAN];

    logic [BCW-1:0]       beat_cnt_d;
    logic                 s2_valid;
    logic                 s2_first;
    logic                 s2_last;
    logic [BUS_WIDTH-1:0] s2_beat;
    logic [BCW-1:0]       s2_cnt;

    logic [CNT_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] acc_d;

    assign en      = ~o_Valid | i_Ready;
    assign o_Ready = en;
    assign accept  = i_Valid & en;

    // Zero padding lets a partial last granule share the same counting loop.
    always_comb begin
        padded = '0;
        padded[BUS_WIDTH-1:0] = i_Vector;
        for (int unsigned g = 0; g < NUM_GRAN; g++) begin
            gran_cnt_d[g] = '0;
            for (int unsigned b = 0; b < GRANULE_WIDTH; b++) begin
                gran_cnt_d[g] = gran_cnt_d[g] + GCW'(padded[g * GRANULE_WIDTH + b]);
            end
        end
    end

    always_comb begin
        beat_cnt_d = '0;
        for (int unsigned g = 0; g < NUM_GRAN; g++) begin
            beat_cnt_d = beat_cnt_d + BCW'(s1_gran[g]);
        end
    end

    always_comb begin
        acc_d = s2_first ? CNT_WIDTH'(s2_cnt) : acc + CNT_WIDTH'(s2_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx <= '0;
        end else if (accept) begin
            beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_beat     <= '0;
            for (int unsigned g = 0; g < NUM_GRAN; g++) begin
                s1_gran[g] <= '0;
            end
            s2_valid    <= 1'b0;
            s2_first    <= 1'b0;
            s2_last     <= 1'b0;
            s2_beat     <= '0;
            s2_cnt      <= '0;
            acc         <= '0;
            o_Valid     <= 1'b0;
            o_Last      <= 1'b0;
            o_Cnt       <= '0;
            o_SubVector <= '0;
        end else if (en) begin
            s1_valid <= i_Valid;
            s1_first <= (beat_idx == '0);
            s1_last  <= (beat_idx == LAST_IDX);
            s1_beat  <= i_Vector;
            for (int unsigned g = 0; g < NUM_GRAN; g++) begin
                s1_gran[g] <= gran_cnt_d[g];
            end

            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_beat  <= s1_beat;
            s2_cnt   <= beat_cnt_d;

            if (s2_valid) begin
                acc <= acc_d;
            end
            o_Valid     <= s2_valid;
            o_Last      <= s2_valid & s2_last;
            o_Cnt       <= (s2_valid && s2_last) ? acc_d : '0;
            o_SubVector <= s2_valid ? s2_beat : '0;
        end
    end

endmodule
